inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Parametrised instruction-fetch front end: generates sequential instruction addresses, issues them to instruction memory and tracks outstanding reads.
- Buffers returned words with their PCs in a queue; presents them to decode_1st under valid/ready backpressure.
- Accepts a redirect (FLUSH) from later stages: the queue is discarded, in-flight responses are dropped, and fetching restarts at a new PC.
- Replaces the free-running PC counter at the fetch stage of core.

Parameters:
XLEN, 32, address/data width in bits.
QUEUE_DEPTH, 4, fetch queue entries; also the credit limit on in-flight plus buffered fetches (power of 2, >=2).
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
CLK  in  1  clock, all state updates on posedge.
RST  in  1  synchronous, active-high reset.
INST_RDEN  out  1  read request valid (registered).
INST_RADDR  out  XLEN  read address, word aligned (registered).
MEM_WAIT  in  1  memory not accepting; request accepted on a cycle with INST_RDEN=1 and MEM_WAIT=0.
INST_RVALID  in  1  read response valid; responses return in order, at least 1 cycle after acceptance.
INST_RDATA  in  XLEN  read response data.
FLUSH  in  1  redirect pulse.
FLUSH_PC  in  XLEN  redirect target; bits [1:0] forced to 0.
FETCH_VALID  out  1  queue head valid.
FETCH_PC  out  XLEN  PC of head entry.
FETCH_DATA  out  XLEN  instruction of head entry.
FETCH_READY  in  1  decode consumes head when FETCH_VALID && FETCH_READY.

Behaviour:
- Reset: INST_RDEN=0, INST_RADDR=0, FETCH_VALID=0, FETCH_PC=0, FETCH_DATA=0. The queue is emptied, the outstanding and drop counters are cleared, next_pc=RESET_PC and resp_pc=RESET_PC. Reset mid-operation abandons all in-flight requests without drop tracking; memory is reset alongside.
- Credits: credit = queue_count + outstanding + (INST_RDEN ? 1 : 0). This prevents queue overflow.
- Issue, evaluated each edge when !INST_RDEN || !MEM_WAIT:
  - If credit after this edge's pushes/pops/acceptances < QUEUE_DEPTH: INST_RDEN<=1, INST_RADDR<=next_pc, next_pc<=next_pc+4.
  - Otherwise INST_RDEN<=0.
- While INST_RDEN && MEM_WAIT, INST_RDEN and INST_RADDR hold.
- First request appears 1 cycle after RST deasserts.
- Address arithmetic is modulo 2^XLEN: 0xFFFF_FFFC+4 wraps to 0.
- Outstanding counter: +1 on acceptance, -1 on INST_RVALID; both in one cycle leaves it unchanged. INST_RVALID with nothing outstanding is ignored and the counter does not underflow.
- Response with drop_count>0: discarded, drop_count-1, resp_pc unchanged.
- Response with drop_count=0: push {resp_pc, INST_RDATA}, resp_pc+=4.
- A pushed entry is visible on FETCH_* the following cycle (1-cycle latency INST_RVALID -> FETCH_VALID). Push and pop in the same cycle are allowed.
- Queue is show-ahead: FETCH_* reflect the head combinationally from registers; FETCH_PC and FETCH_DATA read 0 when empty. Order is strictly FIFO.
- FLUSH has priority over push, pop and issue at that edge:
  - Queue is emptied. A response arriving in the flush cycle is discarded.
  - drop_count <= outstanding + accepted_this_cycle - returned_this_cycle.
  - A presented but unaccepted request is retracted.
  - INST_RADDR<=FLUSH_PC&~3 and next_pc<=(FLUSH_PC&~3)+4.
  - INST_RDEN<=1 only if drop_count_next < QUEUE_DEPTH, else 0.
  - resp_pc<=FLUSH_PC&~3.
- FLUSH while drop_count>0 accumulates correctly (new drop_count covers all old in-flight requests).
- No combinational path from MEM_WAIT, INST_RVALID, FLUSH or FETCH_READY to INST_RDEN or INST_RADDR.

Test Plan:
1. Reset then stream, memory latency 2, MEM_WAIT=0, FETCH_READY=1 -> FETCH_PC 0x0,0x4,0x8,... with FETCH_DATA matching memory, first FETCH_VALID 4 cycles after RST deasserts, no gaps in steady state.
2. FETCH_READY=0 throughout -> exactly 4 requests accepted, INST_RDEN drops to 0, queue holds PCs 0x0-0xC. Raising READY then drains in order and issuing resumes at 0x10.
3. MEM_WAIT high 3 cycles while presenting 0x8 -> INST_RADDR holds 0x8, no duplicate or skipped PC downstream.
4. FLUSH with FLUSH_PC=0x1003 while 2 requests outstanding and 1 queued -> queue empties, the next 2 INST_RVALIDs are discarded, and the first FETCH_PC is 0x1000 followed by 0x1004.
5. FLUSH in the same cycle as INST_RVALID and a request acceptance -> response discarded, drop_count correct, no stale PC ever reaches FETCH_*.
6. RST asserted mid-stream with entries queued -> next cycle FETCH_VALID=0 and INST_RDEN=0, fetching restarts at RESET_PC; also check wrap 0xFFFF_FFFC -> 0x0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: sequential PC generation, credit-limited memory requests,
// a show-ahead fetch queue toward decode, and redirect handling that drops in-flight reads.
module inst_fetch #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            INST_RDEN,
  output logic [XLEN-1:0] INST_RADDR,
  input  logic            MEM_WAIT,
  input  logic            INST_RVALID,
  input  logic [XLEN-1:0] INST_RDATA,
  input  logic            FLUSH,
  input  logic [XLEN-1:0] FLUSH_PC,
  output logic            FETCH_VALID,
  output logic [XLEN-1:0] FETCH_PC,
  output logic [XLEN-1:0] FETCH_DATA,
  input  logic            FETCH_READY
);

  localparam int unsigned     PW         = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned     CW         = PW + 1;
  localparam int unsigned     SW         = CW + 1;
  localparam logic [SW-1:0]   DEPTH_W    = SW'(QUEUE_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            rden_q, rden_d;
  logic [XLEN-1:0] raddr_q, raddr_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;

  logic [XLEN-1:0] pc_mem   [QUEUE_DEPTH];
  logic [XLEN-1:0] data_mem [QUEUE_DEPTH];

  logic            accept;
  logic            ret;
  logic            drop_resp;
  logic            push;
  logic            pop;
  logic            can_issue;
  logic [SW-1:0]   credit_d;
  logic [XLEN-1:0] flush_pc;

  assign INST_RDEN   = rden_q;
  assign INST_RADDR  = raddr_q;
  assign FETCH_VALID = (count_q != '0);
  assign FETCH_PC    = FETCH_VALID ? pc_mem[rd_q] : '0;
  assign FETCH_DATA  = FETCH_VALID ? data_mem[rd_q] : '0;

  always_comb begin
    accept    = rden_q && !MEM_WAIT;
    // A response with nothing outstanding is spurious and ignored.
    ret       = INST_RVALID && (outst_q != '0);
    drop_resp = ret && (drop_q != '0);
    push      = ret && !drop_resp && !FLUSH;
    pop       = FETCH_VALID && FETCH_READY && !FLUSH;
    flush_pc  = FLUSH_PC & ALIGN_MASK;

    rden_d    = rden_q;
    raddr_d   = raddr_q;
    next_pc_d = next_pc_q;
    resp_pc_d = resp_pc_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    drop_d    = drop_q;
    outst_d   = outst_q + CW'(accept) - CW'(ret);
    credit_d  = '0;
    can_issue = 1'b0;

    if (FLUSH) begin
      // Everything still in flight after this edge belongs to the old path.
      count_d   = '0;
      rd_d      = '0;
      wr_d      = '0;
      drop_d    = outst_d;
      resp_pc_d = flush_pc;
      raddr_d   = flush_pc;
      credit_d  = SW'(outst_d);
      can_issue = (credit_d < DEPTH_W);
      rden_d    = can_issue;
      next_pc_d = can_issue ? flush_pc + PC_STEP : flush_pc;
    end else begin
      count_d   = count_q + CW'(push) - CW'(pop);
      drop_d    = drop_q - CW'(drop_resp);
      if (push) begin
        wr_d      = wr_q + PW'(1);
        resp_pc_d = resp_pc_q + PC_STEP;
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      credit_d = SW'(count_d) + SW'(outst_d);
      if (!rden_q || !MEM_WAIT) begin
        can_issue = (credit_d < DEPTH_W);
        rden_d    = can_issue;
        if (can_issue) begin
          raddr_d   = next_pc_q;
          next_pc_d = next_pc_q + PC_STEP;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rden_q    <= 1'b0;
      raddr_q   <= '0;
      next_pc_q <= RESET_PC;
      resp_pc_q <= RESET_PC;
      count_q   <= '0;
      outst_q   <= '0;
      drop_q    <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
    end else begin
      rden_q    <= rden_d;
      raddr_q   <= raddr_d;
      next_pc_q <= next_pc_d;
      resp_pc_q <= resp_pc_d;
      count_q   <= count_d;
      outst_q   <= outst_d;
      drop_q    <= drop_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
    end
  end

  // Queue storage needs no reset: the head is only exposed while count_q is non-zero.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_q]   <= resp_pc_q;
      data_mem[wr_q] <= INST_RDATA;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: an in-order memory model with fixed latency feeds the DUT;
// expected PCs are queued by the stimulus and popped by a monitor on each decode handshake.
module tb_inst_fetch;

  logic        CLK;
  logic        RST;
  logic        INST_RDEN;
  logic [31:0] INST_RADDR;
  logic        MEM_WAIT;
  logic        INST_RVALID;
  logic [31:0] INST_RDATA;
  logic        FLUSH;
  logic [31:0] FLUSH_PC;
  logic        FETCH_VALID;
  logic [31:0] FETCH_PC;
  logic [31:0] FETCH_DATA;
  logic        FETCH_READY;

  int          n_vec     = 0;
  int          n_err     = 0;
  int          ecnt      = 0;
  int          mem_lat   = 2;
  int          acc_count = 0;
  logic [31:0] exp_q    [$];
  logic [31:0] pend_a   [$];
  int          pend_due [$];

  inst_fetch #(
    .XLEN        (32),
    .QUEUE_DEPTH (4),
    .RESET_PC    (32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .INST_RDEN   (INST_RDEN),
    .INST_RADDR  (INST_RADDR),
    .MEM_WAIT    (MEM_WAIT),
    .INST_RVALID (INST_RVALID),
    .INST_RDATA  (INST_RDATA),
    .FLUSH       (FLUSH),
    .FLUSH_PC    (FLUSH_PC),
    .FETCH_VALID (FETCH_VALID),
    .FETCH_PC    (FETCH_PC),
    .FETCH_DATA  (FETCH_DATA),
    .FETCH_READY (FETCH_READY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) ecnt <= ecnt + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0F96;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Memory model: decides acceptance and response for the coming posedge.
  task automatic mem_model();
    int upcoming;
    if (RST) begin
      pend_a.delete();
      pend_due.delete();
      INST_RVALID = 1'b0;
      INST_RDATA  = '0;
      return;
    end
    upcoming = ecnt + 1;
    if (INST_RDEN && !MEM_WAIT) begin
      pend_a.push_back(INST_RADDR);
      pend_due.push_back(upcoming + mem_lat);
      acc_count++;
    end
    if (pend_due.size() > 0 && pend_due[0] <= upcoming) begin
      INST_RVALID = 1'b1;
      INST_RDATA  = mem_word(pend_a.pop_front());
      void'(pend_due.pop_front());
    end else begin
      INST_RVALID = 1'b0;
      INST_RDATA  = '0;
    end
  endtask

  task automatic step();
    mem_model();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST         = 1'b1;
    FLUSH       = 1'b0;
    FLUSH_PC    = '0;
    MEM_WAIT    = 1'b0;
    FETCH_READY = 1'b0;
    step();
    step();
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    logic [31:0] pc;
    pc = base;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(pc);
      pc = pc + 32'd4;
    end
  endtask

  task automatic drain(input int maxc, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < maxc) begin
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d entries still expected, required 0", exp_q.size());
      exp_q.delete();
    end
    FETCH_READY = 1'b0;
  endtask

  // Monitor: compares the head against the scoreboard on every consuming handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      #2;
      if (FETCH_VALID && FETCH_READY) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_fetch: got pc=%h, required no entry", FETCH_PC);
        end else begin
          e = exp_q.pop_front();
          if (FETCH_PC !== e || FETCH_DATA !== mem_word(e)) begin
            n_err++;
            $display("FAIL fetch_order: got pc=%h data=%h, required pc=%h data=%h",
                     FETCH_PC, FETCH_DATA, e, mem_word(e));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    INST_RVALID = 1'b0;
    INST_RDATA  = '0;
    @(negedge CLK);

    // 1: reset values, then streaming with READY high
    mem_lat = 2;
    do_reset();
    check("rst_rden", 32'(INST_RDEN), 32'd0);
    check("rst_raddr", INST_RADDR, 32'h0);
    check("rst_fvalid", 32'(FETCH_VALID), 32'd0);
    check("rst_fpc", FETCH_PC, 32'h0);
    check("rst_fdata", FETCH_DATA, 32'h0);
    push_seq(32'h0, 8);
    FETCH_READY = 1'b1;
    RST = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!FETCH_VALID && n < 20);
    check("t1_first_valid_latency", 32'(n), 32'd4);
    drain(40, n);
    check("t1_no_gap_cycles", 32'(n), 32'd8);

    // 2: READY low, credits stop issue at QUEUE_DEPTH
    do_reset();
    acc_count = 0;
    RST = 1'b0;
    repeat (12) step();
    check("t2_accepted", 32'(acc_count), 32'd4);
    check("t2_rden_low", 32'(INST_RDEN), 32'd0);
    check("t2_head_valid", 32'(FETCH_VALID), 32'd1);
    check("t2_head_pc", FETCH_PC, 32'h0);
    push_seq(32'h0, 6);
    FETCH_READY = 1'b1;
    drain(40, n);

    // 3: MEM_WAIT stall while presenting 0x8
    do_reset();
    push_seq(32'h0, 8);
    FETCH_READY = 1'b1;
    RST = 1'b0;
    n = 0;
    while (!(INST_RDEN && INST_RADDR == 32'h8) && n < 20) begin
      step();
      n++;
    end
    for (int i = 0; i < 3; i++) begin
      MEM_WAIT = 1'b1;
      step();
      check("t3_hold_rden", 32'(INST_RDEN), 32'd1);
      check("t3_hold_raddr", INST_RADDR, 32'h8);
    end
    MEM_WAIT = 1'b0;
    drain(40, n);

    // 4: flush with 2 outstanding and 1 queued (latency 3, one stall to shape it)
    mem_lat = 3;
    do_reset();
    RST = 1'b0;
    step();
    step();
    MEM_WAIT = 1'b1;
    step();
    MEM_WAIT = 1'b0;
    step();
    step();
    check("t4_pre_valid", 32'(FETCH_VALID), 32'd1);
    check("t4_pre_pc", FETCH_PC, 32'h0);
    FLUSH    = 1'b1;
    FLUSH_PC = 32'h0000_1003;
    MEM_WAIT = 1'b1;
    step();
    FLUSH    = 1'b0;
    MEM_WAIT = 1'b0;
    check("t4_empty", 32'(FETCH_VALID), 32'd0);
    check("t4_raddr", INST_RADDR, 32'h0000_1000);
    check("t4_rden", 32'(INST_RDEN), 32'd1);
    push_seq(32'h0000_1000, 3);
    FETCH_READY = 1'b1;
    drain(40, n);

    // 5: flush coincides with a response and an acceptance
    mem_lat = 2;
    do_reset();
    RST = 1'b0;
    step();
    step();
    step();
    FLUSH    = 1'b1;
    FLUSH_PC = 32'h0000_2000;
    step();
    FLUSH = 1'b0;
    check("t5_empty", 32'(FETCH_VALID), 32'd0);
    check("t5_raddr", INST_RADDR, 32'h0000_2000);
    push_seq(32'h0000_2000, 3);
    FETCH_READY = 1'b1;
    drain(40, n);

    // 6: reset mid-stream, then back-to-back flushes into the address wrap
    do_reset();
    RST = 1'b0;
    repeat (8) step();
    check("t6_prefill_valid", 32'(FETCH_VALID), 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("t6_rst_fvalid", 32'(FETCH_VALID), 32'd0);
    check("t6_rst_rden", 32'(INST_RDEN), 32'd0);
    check("t6_rst_fpc", FETCH_PC, 32'h0);
    push_seq(32'h0, 3);
    FETCH_READY = 1'b1;
    drain(40, n);
    FLUSH    = 1'b1;
    FLUSH_PC = 32'h0000_3000;
    step();
    FLUSH_PC = 32'hFFFF_FFF9;
    step();
    FLUSH = 1'b0;
    check("t6_flush_raddr", INST_RADDR, 32'hFFFF_FFF8);
    check("t6_flush_rden", 32'(INST_RDEN), 32'd1);
    push_seq(32'hFFFF_FFF8, 4);
    FETCH_READY = 1'b1;
    drain(40, n);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
